// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Bundle of the UART receiver's line, configuration and
//               received-frame signals.
//               master : line driver / frame consumer (drives rx, parity_en,
//                        clk_per_bit; reads rx_data, rx_valid, frame_error,
//                        parity_error, rx_busy)
//               slave  : the receiver itself
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 parity_en;
    logic [12:0]          clk_per_bit;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 parity_error;
    logic                 rx_busy;

    modport master (
        output rx, parity_en, clk_per_bit,
        input  rx_data, rx_valid, frame_error, parity_error, rx_busy
    );

    modport slave (
        input  rx, parity_en, clk_per_bit,
        output rx_data, rx_valid, frame_error, parity_error, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. Synchronizes rx, confirms the
//               start bit at mid-bit, shifts in an LSB-first word, optionally
//               checks even parity and checks the stop bit. Each completed
//               frame produces a one-cycle rx_valid with sticky error flags.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous active-high reset
//               bus  - uart_rx_if.slave (rx, parity_en, clk_per_bit in;
//                      rx_data, rx_valid, frame_error, parity_error,
//                      rx_busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    uart_rx_if.slave     bus
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [12:0]            r_cpb;
    logic [12:0]            r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_en;
    logic                   r_par_err;

    logic                   w_rx_s;
    logic [12:0]            w_cpb_clamped;
    logic [12:0]            w_half;
    logic                   w_bit_end;

    // Line idles high, so the synchronizer resets to 1 to avoid a false
    // start bit coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx};
        end
    end

    assign w_rx_s        = r_sync[SYNC_STAGES-1];
    assign w_cpb_clamped = (bus.clk_per_bit < 13'd4) ? 13'd4 : bus.clk_per_bit;
    assign w_half        = r_cpb >> 1;
    assign w_bit_end     = (r_cnt == r_cpb - 13'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cpb            <= 13'd4;
            r_cnt            <= '0;
            r_idx            <= '0;
            r_shift          <= '0;
            r_par_en         <= 1'b0;
            r_par_err        <= 1'b0;
            bus.rx_data      <= '0;
            bus.rx_valid     <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.parity_error <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cpb   <= w_cpb_clamped;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == w_half - 13'd1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_par_en  <= bus.parity_en;
                            r_idx     <= '0;
                            r_par_err <= 1'b0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Right shift: after DATA_BITS samples bit 0 sits at
                        // the LSB, matching LSB-first transmission.
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        // Even parity: data plus parity bit must XOR to 0.
                        r_par_err <= (^r_shift) ^ w_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt            <= '0;
                        bus.rx_data      <= r_shift;
                        bus.rx_valid     <= 1'b1;
                        bus.frame_error  <= ~w_rx_s;
                        bus.parity_error <= r_par_en & r_par_err;
                        r_state          <= w_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                S_BREAK: begin
                    // A held-low line must return high before another start
                    // bit can be recognised, so a break yields one frame.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with an expected-
//               frame queue filled when frames are sent and drained when
//               rx_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DATA_BITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx #(
        .DATA_BITS   (DATA_BITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb[$];

    int checks          = 0;
    int errors          = 0;
    int valid_cnt       = 0;
    int cyc             = 0;
    int last_valid_cyc  = 0;
    int frame_start_cyc = 0;
    int v0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        sb.push_back(e);
    endtask

    // Scoreboard side: each rx_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            exp_t e;
            valid_cnt++;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_data",      {24'd0, bus.rx_data}, {24'd0, e.data});
                chk("frame_error",  {31'd0, bus.frame_error},  {31'd0, e.fe});
                chk("parity_error", {31'd0, bus.parity_error}, {31'd0, e.pe});
            end
        end
    end

    task automatic send_bit(input logic b, input int n);
        bus.rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic par,
                              input logic par_bit, input logic stop);
        frame_start_cyc = cyc;
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
        if (par) send_bit(par_bit, n);
        send_bit(stop, n);
    endtask

    initial begin
        logic [7:0] d;
        bus.rx          = 1'b1;
        bus.parity_en   = 1'b0;
        bus.clk_per_bit = 13'd16;
        rst             = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset_rx_data",      {24'd0, bus.rx_data},       32'd0);
        chk("reset_rx_valid",     {31'd0, bus.rx_valid},      32'd0);
        chk("reset_frame_error",  {31'd0, bus.frame_error},   32'd0);
        chk("reset_parity_error", {31'd0, bus.parity_error},  32'd0);
        chk("reset_rx_busy",      {31'd0, bus.rx_busy},       32'd0);

        rst = 1'b0;
        idle(4);

        // Plain frame, no parity
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1);
        idle(16);
        chk("t1_latency", last_valid_cyc - frame_start_cyc, 32'd155);
        chk("t1_busy",    {31'd0, bus.rx_busy}, 32'd0);
        chk("t1_count",   valid_cnt, 32'd1);
        chk("t1_sb",      sb.size(), 32'd0);

        // Parity enabled: good then bad parity bit
        bus.parity_en = 1'b1;
        push(8'h37, 1'b0, 1'b0);
        send_frame(8'h37, 16, 1'b1, 1'b1, 1'b1);
        idle(16);
        chk("t2_latency", last_valid_cyc - frame_start_cyc, 32'd171);
        push(8'h37, 1'b0, 1'b1);
        send_frame(8'h37, 16, 1'b1, 1'b0, 1'b1);
        idle(16);
        chk("t2_pe_held", {31'd0, bus.parity_error}, 32'd1);
        chk("t2_sb",      sb.size(), 32'd0);

        // Frame error followed by a long break
        bus.parity_en = 1'b0;
        v0 = valid_cnt;
        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 40 * 16);
        chk("t3_one_frame", valid_cnt - v0, 32'd1);
        chk("t3_busy_break", {31'd0, bus.rx_busy}, 32'd1);
        idle(48);
        chk("t3_no_more", valid_cnt - v0, 32'd1);
        chk("t3_fe_held", {31'd0, bus.frame_error}, 32'd1);
        chk("t3_busy_idle", {31'd0, bus.rx_busy}, 32'd0);

        // Start glitch of 3 clocks
        v0 = valid_cnt;
        send_bit(1'b0, 3);
        idle(40);
        chk("t4_no_valid", valid_cnt - v0, 32'd0);
        chk("t4_fe_kept",  {31'd0, bus.frame_error}, 32'd1);
        chk("t4_data_kept", {24'd0, bus.rx_data}, 32'h3C);
        chk("t4_busy",     {31'd0, bus.rx_busy}, 32'd0);

        // Back-to-back at CPB=5, then CPB=2 (clamped to 4)
        bus.clk_per_bit = 13'd5;
        v0 = valid_cnt;
        push(8'h00, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 5, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("t5_b2b_count", valid_cnt - v0, 32'd2);
        bus.clk_per_bit = 13'd2;
        v0 = valid_cnt;
        push(8'h96, 1'b0, 1'b0);
        push(8'h69, 1'b0, 1'b0);
        send_frame(8'h96, 4, 1'b0, 1'b0, 1'b1);
        send_frame(8'h69, 4, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("t5_clamp_count", valid_cnt - v0, 32'd2);
        chk("t5_sb", sb.size(), 32'd0);

        // Reset during data bit 4
        bus.clk_per_bit = 13'd16;
        v0 = valid_cnt;
        d = 8'hC3;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        bus.rx = d[4];
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_data",  {24'd0, bus.rx_data},      32'd0);
        chk("t6_rst_valid", {31'd0, bus.rx_valid},     32'd0);
        chk("t6_rst_fe",    {31'd0, bus.frame_error},  32'd0);
        chk("t6_rst_pe",    {31'd0, bus.parity_error}, 32'd0);
        chk("t6_rst_busy",  {31'd0, bus.rx_busy},      32'd0);
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20);
        chk("t6_no_valid", valid_cnt - v0, 32'd0);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1);
        idle(16);
        chk("t6_after_count", valid_cnt - v0, 32'd1);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
